// File: rtl/drum_pkg.sv
// Shared types and defaults for the drum-pad input conditioner.
// Counter build option: DRUM_HIT_COUNT_EN.
package drum_pkg;

  localparam int NUM_CH_DFLT   = 3;
  localparam int DEBOUNCE_DFLT = 250000;
  localparam int HOLD_DFLT     = 3000000;
  localparam int CNT_W_DFLT    = 8;

  localparam int CH_KICK  = 0;
  localparam int CH_SNARE = 1;
  localparam int CH_HAT   = 2;

  typedef enum logic [1:0] {
    UNARMED,
    RELEASED,
    PRESSED
  } hit_state_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drum_hit_conditioner_if.sv
// Pad-side and pattern-side signals of the drum-pad conditioner.
// Counter build option: DRUM_HIT_COUNT_EN.
interface drum_hit_conditioner_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8
);

  logic [NUM_CH-1:0]       hit_i;
  logic                    clr_i;
  logic [NUM_CH-1:0]       hit_pulse_o;
  logic                    any_hit_o;
  logic [NUM_CH-1:0]       flash_o;
  logic [NUM_CH*CNT_W-1:0] hit_count_o;

  modport master (
    output hit_i,
    output clr_i,
    input  hit_pulse_o,
    input  any_hit_o,
    input  flash_o,
    input  hit_count_o
  );

  modport slave (
    input  hit_i,
    input  clr_i,
    output hit_pulse_o,
    output any_hit_o,
    output flash_o,
    output hit_count_o
  );

endinterface

// File: rtl/hit_channel.sv
// One drum pad: sync, debounce, arm/press FSM, hit pulse, flash, counter.
// Counter build option: DRUM_HIT_COUNT_EN.
module hit_channel
  import drum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DFLT,
  parameter int HOLD_CYCLES     = HOLD_DFLT,
  parameter int CNT_W           = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit_i,
  input  logic             clr_i,
  output logic             pulse_d,
  output logic             hit_pulse_o,
  output logic             flash_o,
  output logic [CNT_W-1:0] hit_count_o
);

  // The arm window must outlast the synchroniser fill after reset,
  // otherwise a pad held through reset would look released.
  localparam int ARM_CYCLES =
    (DEBOUNCE_CYCLES > 4) ? DEBOUNCE_CYCLES : 4;
  localparam int DW = cw(DEBOUNCE_CYCLES);
  localparam int AW = cw(ARM_CYCLES);
  localparam int HW = cw(HOLD_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] A_LAST = AW'(ARM_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [DW-1:0] dcnt;
  logic [AW-1:0] acnt;
  logic          arm_done;
  hit_state_t    state;
  hit_state_t    nxt;
  logic          pulse_q;
  logic          flash_q;
  logic [HW-1:0] hcnt;

  // Two-flop synchroniser for the asynchronous pad level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= hit_i;
      s2 <= s1;
    end
  end

  // Accept a new level only after it holds unbroken for the full window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 1'b0;
      dcnt   <= '0;
    end else if (s2 == stable) begin
      dcnt <= '0;
    end else if (dcnt == D_LAST) begin
      stable <= s2;
      dcnt   <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  assign arm_done = (acnt == A_LAST);

  // Arm timer: the synchronised pad must read low for a full window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acnt <= '0;
    end else if (state != UNARMED || s2) begin
      acnt <= '0;
    end else if (!arm_done) begin
      acnt <= acnt + 1'b1;
    end
  end

  // Press FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= UNARMED;
    else       state <= nxt;
  end

  // Press FSM next state; UNARMED waits for a genuine release.
  always_comb begin
    nxt = state;
    unique case (state)
      UNARMED:  if (!stable && !s2 && arm_done) nxt = RELEASED;
      RELEASED: if (stable)  nxt = PRESSED;
      PRESSED:  if (!stable) nxt = RELEASED;
      default:  nxt = UNARMED;
    endcase
  end

  // Press FSM output: pulse on entry to PRESSED, registered below.
  always_comb begin
    pulse_d = (state == RELEASED) && (nxt == PRESSED);
  end

  // Hit pulse register, aligned with the first PRESSED cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pulse_q <= 1'b0;
    else       pulse_q <= pulse_d;
  end

  // Flash stretcher; a new hit reloads so the flash never gaps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_q <= 1'b0;
      hcnt    <= '0;
    end else if (pulse_q) begin
      flash_q <= 1'b1;
      hcnt    <= H_LAST;
    end else if (flash_q) begin
      if (hcnt == '0) flash_q <= 1'b0;
      else            hcnt    <= hcnt - 1'b1;
    end
  end

  assign hit_pulse_o = pulse_q;
  assign flash_o     = flash_q;

`ifdef DRUM_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt;

  // Saturating hit counter; clear beats a coincident hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (pulse_q && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit_count_o = cnt;
`else
  logic unused_clr;

  assign unused_clr  = clr_i;
  assign hit_count_o = '0;
`endif

endmodule

// File: rtl/drum_hit_conditioner.sv
// Drum-pad front end: NUM_CH independent pad channels plus any-hit strobe.
// Counter build option: DRUM_HIT_COUNT_EN.
module drum_hit_conditioner
  import drum_pkg::*;
#(
  parameter int NUM_CH          = NUM_CH_DFLT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DFLT,
  parameter int HOLD_CYCLES     = HOLD_DFLT,
  parameter int CNT_W           = CNT_W_DFLT
) (
  input logic                   clk,
  input logic                   reset,
  drum_hit_conditioner_if.slave bus
);

  logic [NUM_CH-1:0]       pulse_d;
  logic [NUM_CH-1:0]       pulse_v;
  logic [NUM_CH-1:0]       flash_v;
  logic [NUM_CH*CNT_W-1:0] count_v;
  logic                    any_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hit_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .hit_i       (bus.hit_i[g]),
      .clr_i       (bus.clr_i),
      .pulse_d     (pulse_d[g]),
      .hit_pulse_o (pulse_v[g]),
      .flash_o     (flash_v[g]),
      .hit_count_o (count_v[g*CNT_W +: CNT_W])
    );
  end

  // Any-hit strobe registered from the pulse precursors so it
  // lines up with the per-channel pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_q <= 1'b0;
    else       any_q <= |pulse_d;
  end

  assign bus.hit_pulse_o = pulse_v;
  assign bus.any_hit_o   = any_q;
  assign bus.flash_o     = flash_v;
  assign bus.hit_count_o = count_v;

endmodule
